// File: rtl/inmem_pkg.sv
// Shared constants and the reader state encoding for the input-memory read path.
// Optional build macro used by inmem_reader: INMEM_READER_ABORT_EN.
package inmem_pkg;

    localparam int ADDR_W = 6;     // 64 rows
    localparam int DATA_W = 2048;  // merged row: BANKS x BANK_W
    localparam int BANKS  = 8;
    localparam int BANK_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/inmem_rd_fifo.sv
// Small register FIFO with first-word-fall-through output. The head entry is
// always visible on data_o, so a stalled consumer sees a stable word.
module inmem_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] occ_q;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (occ_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (occ_q != '0);
    assign occ_o   = occ_q;

    // Storage, pointers and occupancy; clear drops contents but keeps storage values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            occ_q <= occ_q + CW'(push_i) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inmem_reader.sv
// Matmul-side read sequencer: walks a row range on BRAM port B, absorbs the
// read latency and streams merged rows out with full backpressure.
// Optional build macro: INMEM_READER_ABORT_EN adds an 'abort' input.
module inmem_reader
    import inmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   row_count,
    output logic              busy,
    output logic              done,
    output logic              en_b_unified,
    output logic [ADDR_W-1:0] addr_b_unified,
    input  logic [DATA_W-1:0] dout_b_merged,
    output logic [DATA_W-1:0] row_data,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_last
`ifdef INMEM_READER_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int DEPTH = RD_LAT + 1;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int CW    = FW + 1;

    rd_state_e         state_q;
    logic              busy_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q, issued_q;
    logic [RD_LAT-1:0] vld_q, lst_q;

    logic [FW-1:0]     fifo_occ;
    logic [CW-1:0]     inflight, credit;
    logic [DATA_W:0]   fifo_dout;
    logic              pop, issue, issue_last, push, drain_ok, abort_act;

`ifdef INMEM_READER_ABORT_EN
    assign abort_act = abort && (state_q != ST_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    // Reads launched but not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
    end

    // A slot freed by this cycle's pop is reusable now, so issue stays at 1/cycle.
    assign pop        = row_valid && row_ready;
    assign credit     = CW'(fifo_occ) + inflight - CW'(pop);
    assign issue      = (state_q == ST_RUN) && (issued_q < count_q) &&
                        (credit < CW'(DEPTH)) && !abort_act;
    assign issue_last = issue && (issued_q == count_q - (ADDR_W+1)'(1));
    assign push       = vld_q[RD_LAT-1];
    // Finish on the edge of the final handshake so done follows it directly.
    assign drain_ok   = (inflight == '0) && ((CW'(fifo_occ) - CW'(pop)) == '0);

    assign busy           = busy_q;
    assign done           = done_q;
    assign en_b_unified   = issue;
    assign addr_b_unified = addr_q;

    // Command FSM with address/issue counters and registered busy/done.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        addr_q   <= base_addr;
                        count_q  <= row_count;
                        issued_q <= '0;
                        if (row_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RUN: if (issue) begin
                        addr_q   <= addr_q + ADDR_W'(1);  // wraps 63 -> 0
                        issued_q <= issued_q + (ADDR_W+1)'(1);
                        if (issue_last) state_q <= ST_DRAIN;
                    end
                    ST_DRAIN: if (drain_ok) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Read-latency tracker: valid and last flag ride along with each read.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (abort_act) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= issue;
            lst_q[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    inmem_rd_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .clk_i       (clk_b),
        .rst_ni      (rst_n),
        .clr_i       (abort_act),
        .push_i      (push),
        .push_data_i ({lst_q[RD_LAT-1], dout_b_merged}),
        .pop_i       (pop),
        .data_o      (fifo_dout),
        .valid_o     (row_valid),
        .occ_o       (fifo_occ)
    );

    assign row_last = fifo_dout[DATA_W];
    assign row_data = fifo_dout[DATA_W-1:0];

endmodule
